reaction_ctrl: RTL and testbench

Sequencing controller for the reaction-timer datapath. It generates a pseudo-random wait after a start press, then lights the stimulus LED. It measures the reaction time in 1 ms ticks and flags early or late presses. It drives the value and display-mode selectors that the seven-segment multiplexer consumes.

---
 rtl/reaction_ctrl.sv | 159 +++++++++++++++
 tb/tb_reaction_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_ctrl.sv
// Reaction-timer sequencing controller.
// Waits a pseudo-random number of 1 ms ticks after start, lights the stimulus
// LED, then measures the reaction time in ms. Early presses and timeouts are
// reported through ms_value/disp_sel for the seven-segment multiplexer.
module reaction_ctrl #(
   parameter int TICK_DIV     = 100000,
   parameter int MIN_DELAY_MS = 2000,
   parameter int RND_BITS     = 12,
   parameter int RAND_EN      = 1,
   parameter int MAX_MS       = 1000,
   parameter int ERR_VALUE    = 9999
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic        clear,
   output logic        led,
   output logic [13:0] ms_value,
   output logic [2:0]  disp_sel,
   output logic        busy
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
   localparam logic [13:0]   MS_LAST    = 14'(MAX_MS - 1);
   localparam logic [13:0]   MS_MAX     = 14'(MAX_MS);
   localparam logic [13:0]   ERR_CODE   = 14'(ERR_VALUE);
   localparam logic [15:0]   MIN_DELAY  = 16'(MIN_DELAY_MS);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DELAY = 3'd1,
      RUN   = 3'd2,
      DONE  = 3'd3,
      EARLY = 3'd4
   } state_t;

   state_t         state_r;
   logic [PW-1:0]  presc_r;
   logic [15:0]    lfsr_r;
   logic [15:0]    delay_target_r;
   logic [15:0]    dly_cnt_r;
   logic [13:0]    ms_cnt_r;
   logic           tick_s;
   logic [15:0]    rnd_addend_s;

   // Fibonacci LFSR step, taps 16,14,13,11 (x^16+x^14+x^13+x^11+1).
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      logic fb;
      fb = v[0] ^ v[2] ^ v[3] ^ v[5];
      return {fb, v[15:1]};
   endfunction

   assign tick_s       = (presc_r == PRESC_MAX);
   assign rnd_addend_s = (RAND_EN != 0) ?
                         {{(16-RND_BITS){1'b0}}, lfsr_r[RND_BITS-1:0]} : 16'd0;

   // Free-running random source; only reset reloads the seed.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_r <= 16'hACE1;
      end else begin
         lfsr_r <= lfsr_next(lfsr_r);
      end
   end

   // Controller FSM with prescaler, counters and registered display outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= IDLE;
         presc_r        <= {PW{1'b0}};
         delay_target_r <= 16'd0;
         dly_cnt_r      <= 16'd0;
         ms_cnt_r       <= 14'd0;
         led            <= 1'b0;
         ms_value       <= 14'd0;
         disp_sel       <= 3'd0;
         busy           <= 1'b0;
      end else begin
         presc_r <= tick_s ? {PW{1'b0}} : presc_r + PW'(1);
         if (clear) begin
            state_r  <= IDLE;
            led      <= 1'b0;
            ms_value <= 14'd0;
            disp_sel <= 3'd0;
            busy     <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  if (start) begin
                     delay_target_r <= MIN_DELAY + rnd_addend_s;
                     dly_cnt_r      <= 16'd0;
                     presc_r        <= {PW{1'b0}};
                     state_r        <= DELAY;
                     disp_sel       <= 3'd1;
                     busy           <= 1'b1;
                     led            <= 1'b0;
                     ms_value       <= 14'd0;
                  end
               end
               DELAY: begin
                  if (stop) begin
                     state_r  <= EARLY;
                     disp_sel <= 3'd4;
                     busy     <= 1'b0;
                     led      <= 1'b0;
                     ms_value <= ERR_CODE;
                  end else if (tick_s) begin
                     dly_cnt_r <= dly_cnt_r + 16'd1;
                     if (dly_cnt_r == delay_target_r - 16'd1) begin
                        state_r  <= RUN;
                        ms_cnt_r <= 14'd0;
                        presc_r  <= {PW{1'b0}};
                        led      <= 1'b1;
                        disp_sel <= 3'd2;
                        ms_value <= 14'd0;
                     end
                  end
               end
               RUN: begin
                  // A stop on a tick cycle freezes the count without the increment.
                  if (stop) begin
                     state_r  <= DONE;
                     led      <= 1'b0;
                     disp_sel <= 3'd3;
                     busy     <= 1'b0;
                     ms_value <= ms_cnt_r;
                  end else if (tick_s) begin
                     if (ms_cnt_r == MS_LAST) begin
                        ms_cnt_r <= MS_MAX;
                        ms_value <= MS_MAX;
                        state_r  <= DONE;
                        led      <= 1'b0;
                        disp_sel <= 3'd3;
                        busy     <= 1'b0;
                     end else begin
                        ms_cnt_r <= ms_cnt_r + 14'd1;
                        ms_value <= ms_cnt_r + 14'd1;
                     end
                  end
               end
               DONE, EARLY: begin
                  // Result is held until clear or reset.
                  state_r <= state_r;
               end
               default: begin
                  state_r  <= IDLE;
                  led      <= 1'b0;
                  ms_value <= 14'd0;
                  disp_sel <= 3'd0;
                  busy     <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Scoreboard bench for reaction_ctrl: a deterministic instance checked at
// scheduled cycles, and a random-wait instance checked on every LED rise.
module tb_reaction_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, stop = 1'b0, clear = 1'b0;
   logic        led;
   logic [13:0] ms_value;
   logic [2:0]  disp_sel;
   logic        busy;

   logic        start2 = 1'b0, stop2 = 1'b0, clear2 = 1'b0;
   logic        led2;
   logic [13:0] ms_value2;
   logic [2:0]  disp_sel2;
   logic        busy2;

   int          cyc = 0;
   int          nchk = 0;
   int          nfail = 0;
   logic [15:0] m_lfsr = 16'hACE1;
   logic        led2_q = 1'b0;
   bit          seen [32];

   typedef struct packed {
      int          at;
      logic        led;
      logic [13:0] ms;
      logic [2:0]  ds;
      logic        busy;
   } exp_t;

   typedef struct packed {
      int start_edge;
      int tgt;
   } rise_t;

   exp_t  q [$];
   string qn [$];
   rise_t rq [$];

   reaction_ctrl #(.TICK_DIV(4), .MIN_DELAY_MS(3), .RND_BITS(12), .RAND_EN(0),
                   .MAX_MS(20), .ERR_VALUE(9999)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
      .led(led), .ms_value(ms_value), .disp_sel(disp_sel), .busy(busy));

   reaction_ctrl #(.TICK_DIV(4), .MIN_DELAY_MS(3), .RND_BITS(4), .RAND_EN(1),
                   .MAX_MS(20), .ERR_VALUE(9999)) dut_r (
      .clk(clk), .rst(rst), .start(start2), .stop(stop2), .clear(clear2),
      .led(led2), .ms_value(ms_value2), .disp_sel(disp_sel2), .busy(busy2));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference LFSR, taps 16,14,13,11, seeded by reset.
   always @(posedge clk) begin
      if (rst) m_lfsr <= 16'hACE1;
      else     m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
   end

   // Monitor: pops scheduled expectations and LED-rise expectations.
   always @(negedge clk) begin : mon
      exp_t  e;
      string nm;
      rise_t r;
      int    meas;
      while (q.size() > 0 && q[0].at <= cyc) begin
         e  = q.pop_front();
         nm = qn.pop_front();
         nchk++;
         if (e.at != cyc) begin
            nfail++;
            $display("FAIL %s: check scheduled for cycle %0d missed (now %0d)", nm, e.at, cyc);
         end else if ({led, ms_value, disp_sel, busy} !== {e.led, e.ms, e.ds, e.busy}) begin
            nfail++;
            $display("FAIL %s @%0d: got led=%b ms=%0d sel=%0d busy=%b, want led=%b ms=%0d sel=%0d busy=%b",
                     nm, cyc, led, ms_value, disp_sel, busy, e.led, e.ms, e.ds, e.busy);
         end
      end
      if (led2 && !led2_q) begin
         if (rq.size() == 0) begin
            nchk++; nfail++;
            $display("FAIL rand_rise @%0d: got unexpected LED rise, want none", cyc);
         end else begin
            r    = rq.pop_front();
            meas = (cyc - r.start_edge) / 4;
            nchk += 2;
            if (cyc != r.start_edge + r.tgt * 4) begin
               nfail++;
               $display("FAIL rand_wait: got rise at cycle %0d, want %0d (target %0d ticks)",
                        cyc, r.start_edge + r.tgt * 4, r.tgt);
            end
            if (meas < 3 || meas > 18) begin
               nfail++;
               $display("FAIL rand_range: got %0d ticks, want 3..18", meas);
            end
            if (meas >= 0 && meas < 32) seen[meas] = 1'b1;
         end
      end else if (rq.size() > 0 && cyc > rq[0].start_edge + 100) begin
         r = rq.pop_front();
         nchk++; nfail++;
         $display("FAIL rand_timeout: got no LED rise by cycle %0d, want rise at %0d",
                  cyc, r.start_edge + r.tgt * 4);
      end
      led2_q = led2;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic goto(input int t);
      while (cyc < t) step();
   endtask

   task automatic chk(input int at, input string nm, input logic l, input logic [13:0] m,
                      input logic [2:0] d, input logic b);
      exp_t e;
      e.at = at; e.led = l; e.ms = m; e.ds = d; e.busy = b;
      q.push_back(e);
      qn.push_back(nm);
   endtask

   // Pulse start on the deterministic instance; returns the DELAY entry edge.
   task automatic do_start(output int entry);
      start = 1'b1;
      entry = cyc + 1;
      step();
      start = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   initial begin : stim
      int e_r, r_r, tgt, nd;
      // 1. reset and wait
      step(); step();
      chk(cyc, "reset", 1'b0, 14'd0, 3'd0, 1'b0);
      rst = 1'b0;
      step();
      chk(cyc + 1, "start_delay", 1'b0, 14'd0, 3'd1, 1'b1);
      do_start(e_r);
      r_r = e_r + 12;
      chk(r_r - 1, "pre_led", 1'b0, 14'd0, 3'd1, 1'b1);
      chk(r_r, "led_rise", 1'b1, 14'd0, 3'd2, 1'b1);
      // 2. normal reaction
      chk(r_r + 3, "live0", 1'b1, 14'd0, 3'd2, 1'b1);
      chk(r_r + 4, "live1", 1'b1, 14'd1, 3'd2, 1'b1);
      chk(r_r + 21, "live5", 1'b1, 14'd5, 3'd2, 1'b1);
      goto(r_r + 21);
      stop = 1'b1; step(); stop = 1'b0;
      chk(r_r + 22, "done5", 1'b0, 14'd5, 3'd3, 1'b0);
      goto(r_r + 50);
      start = 1'b1; step(); start = 1'b0;
      chk(r_r + 51, "done_start_ign", 1'b0, 14'd5, 3'd3, 1'b0);
      chk(r_r + 121, "done_hold", 1'b0, 14'd5, 3'd3, 1'b0);
      goto(r_r + 121);
      pulse_clear();
      chk(r_r + 122, "clear_idle", 1'b0, 14'd0, 3'd0, 1'b0);
      step();
      // 3. early press
      do_start(e_r);
      chk(e_r + 5, "early_pre", 1'b0, 14'd0, 3'd1, 1'b1);
      goto(e_r + 5);
      stop = 1'b1; step(); stop = 1'b0;
      chk(e_r + 6, "early", 1'b0, 14'd9999, 3'd4, 1'b0);
      chk(e_r + 20, "early_hold", 1'b0, 14'd9999, 3'd4, 1'b0);
      goto(e_r + 21);
      pulse_clear();
      chk(e_r + 22, "early_clear", 1'b0, 14'd0, 3'd0, 1'b0);
      step();
      // 4. timeout
      do_start(e_r);
      r_r = e_r + 12;
      chk(r_r, "to_run", 1'b1, 14'd0, 3'd2, 1'b1);
      chk(r_r + 79, "to_19", 1'b1, 14'd19, 3'd2, 1'b1);
      chk(r_r + 80, "to_done", 1'b0, 14'd20, 3'd3, 1'b0);
      chk(r_r + 90, "to_hold", 1'b0, 14'd20, 3'd3, 1'b0);
      goto(r_r + 90);
      pulse_clear();
      step();
      // 5a. stop on a tick edge wins over the increment
      do_start(e_r);
      r_r = e_r + 12;
      chk(r_r + 7, "tick_pre", 1'b1, 14'd1, 3'd2, 1'b1);
      goto(r_r + 7);
      stop = 1'b1; step(); stop = 1'b0;
      chk(r_r + 8, "stop_on_tick", 1'b0, 14'd1, 3'd3, 1'b0);
      step();
      pulse_clear();
      step();
      // 5b. clear beats stop
      do_start(e_r);
      r_r = e_r + 12;
      chk(r_r + 4, "cs_pre", 1'b1, 14'd1, 3'd2, 1'b1);
      goto(r_r + 4);
      clear = 1'b1; stop = 1'b1; step(); clear = 1'b0; stop = 1'b0;
      chk(r_r + 5, "clear_stop", 1'b0, 14'd0, 3'd0, 1'b0);
      step();
      // 5c. reset mid-RUN
      do_start(e_r);
      r_r = e_r + 12;
      chk(r_r + 6, "rst_pre", 1'b1, 14'd1, 3'd2, 1'b1);
      goto(r_r + 6);
      rst = 1'b1; step(); rst = 1'b0;
      chk(r_r + 7, "rst_mid_run", 1'b0, 14'd0, 3'd0, 1'b0);
      step(); step();
      // 6. random wait on the second instance
      for (int t = 0; t < 200; t++) begin
         int idle;
         idle = $urandom_range(0, 9);
         repeat (idle) step();
         tgt = 3 + int'(m_lfsr[3:0]);
         rq.push_back('{start_edge: cyc + 1, tgt: tgt});
         start2 = 1'b1; step(); start2 = 1'b0;
         for (int k = 0; k < 110 && !led2; k++) step();
         step();
         clear2 = 1'b1; step(); clear2 = 1'b0;
      end
      repeat (5) step();
      // leftovers and distinct-value coverage
      nchk++;
      if (q.size() != 0 || rq.size() != 0) begin
         nfail++;
         $display("FAIL leftover: got %0d pending checks, want 0", q.size() + rq.size());
      end
      nd = 0;
      for (int i = 0; i < 32; i++) if (seen[i]) nd++;
      nchk++;
      if (nd < 8) begin
         nfail++;
         $display("FAIL rand_distinct: got %0d distinct waits, want at least 8", nd);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
